// File: rtl/fetch_queue.sv
// Fetch sequencer: owns the fetch PC, drives the combinational imem address, and
// buffers fetched {pc, instr} pairs in a small prefetch FIFO handed to decode.

module fq_slot #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module fetch_queue #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_q,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [63:0]   instr_pc,
  input  logic          instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 64 + DW;

  typedef struct packed {
    logic [63:0]   pc;
    logic [DW-1:0] instr;
  } fq_entry_t;

  logic [63:0]                 fetch_pc;
  logic [PW:0]                 count;
  logic [PW-1:0]               head, tail;
  logic                        pop, push;
  logic [DEPTH-1:0]            slot_we;
  logic [DEPTH-1:0][EW-1:0]    slot_q;
  fq_entry_t                   wr_ent, rd_ent;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A pop frees a slot in the same edge, so a full queue still streams.
  assign push        = fetch_en & ~redirect_valid & ((count != (PW+1)'(DEPTH)) | pop);
  assign imem_addr   = fetch_pc[AW+1:2];

  assign wr_ent = '{pc: fetch_pc, instr: imem_q};

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign slot_we[g] = push & (tail == PW'(g));
      fq_slot #(.W(EW)) u_slot (
        .clk   (clk),
        .reset (reset),
        .we    (slot_we[g]),
        .d     (wr_ent),
        .q     (slot_q[g])
      );
    end
  endgenerate

  assign rd_ent   = fq_entry_t'(slot_q[head]);
  assign instr    = rd_ent.instr;
  assign instr_pc = rd_ent.pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // Any same-cycle pop is already consumed by decode; everything else is dropped.
      fetch_pc <= redirect_pc & ~64'h3;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 64'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations from the ROM image.
module tb_fetch_queue;
  logic        clk, reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        fetch_en, redirect_valid, instr_ready;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  fetch_queue #(.AW(6), .DW(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, fetch PC a 64-bit counter.
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc = 64'd0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && instr_ready;
      do_push = fetch_en && ((mq.size() < 4) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, ins: rom[m_pc[7:2]]});
        m_pc = m_pc + 64'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && chk_en) begin
      chk("m_valid", instr_valid, mq.size() != 0);
      chk("m_imem_addr", imem_addr, m_pc[7:2]);
      if (mq.size() != 0) begin
        chk("m_instr", instr, mq[0].ins);
        chk("m_instr_pc", instr_pc, mq[0].pc);
      end
    end
  end

  task automatic restart(input bit fen, input bit rdy);
    @(negedge clk);
    reset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; fetch_en = fen; instr_ready = rdy;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  logic [31:0] t1_exp [4];

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    rom[0]  = 32'hf8000001; rom[1]  = 32'hf8008002; rom[2] = 32'hf8000203;
    rom[3]  = 32'h8b050083; rom[4]  = 32'hf8018003; rom[29] = 32'hb4000040;
    rom[30] = 32'hf8080015; rom[63] = 32'h00000000;
    t1_exp[0] = 32'hf8000001; t1_exp[1] = 32'hf8008002;
    t1_exp[2] = 32'hf8000203; t1_exp[3] = 32'h8b050083;

    reset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_imem_addr", imem_addr, 6'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);

    // Streaming from reset
    reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1; chk_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_pc", instr_pc, 64'(i * 4));
      chk("t1_instr", instr, t1_exp[i]);
    end

    // Fill to full, then one push+pop cycle, then full with no pop
    restart(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("full_imem_addr", imem_addr, 6'd4);
    chk("full_pc", instr_pc, 64'h0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("pp_imem_addr", imem_addr, 6'd5);
    chk("pp_pc", instr_pc, 64'h4);
    chk("pp_instr", instr, 32'hf8008002);
    @(negedge clk);
    chk("hold_imem_addr", imem_addr, 6'd5);

    // Redirect while streaming, to an unaligned PC
    restart(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    redirect(64'h76);
    chk("rd_valid", instr_valid, 1'b0);
    chk("rd_imem_addr", imem_addr, 6'd29);
    @(negedge clk);
    chk("rd_pc0", instr_pc, 64'h74);
    chk("rd_instr0", instr, 32'hb4000040);
    @(negedge clk);
    chk("rd_pc1", instr_pc, 64'h78);
    chk("rd_instr1", instr, 32'hf8080015);

    // imem address wrap at the top of the ROM
    redirect(64'hFC);
    chk("wr_imem_addr", imem_addr, 6'd63);
    @(negedge clk);
    chk("wr_pc0", instr_pc, 64'hFC);
    chk("wr_instr0", instr, 32'h0);
    chk("wr_imem_addr0", imem_addr, 6'd0);
    @(negedge clk);
    chk("wr_pc1", instr_pc, 64'h100);
    chk("wr_instr1", instr, 32'hf8000001);

    // Drain with fetch disabled, then resume
    restart(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    fetch_en = 1'b0; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("dr_valid", instr_valid, 1'b0);
    chk("dr_imem_addr", imem_addr, 6'd2);
    fetch_en = 1'b1;
    @(negedge clk);
    chk("dr_pc", instr_pc, 64'h8);
    chk("dr_instr", instr, 32'hf8000203);

    // Asynchronous reset mid-stream with three entries queued
    restart(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_imem_addr", imem_addr, 6'd0);
    @(negedge clk);
    reset = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    chk("ar_pc", instr_pc, 64'h0);
    chk("ar_instr", instr, 32'hf8000001);

    // Randomized traffic, including redirects near the 64-bit wrap
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fetch_en       = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = {$urandom(), $urandom()};
        1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: redirect_pc = 64'($urandom_range(0, 255));
      endcase
    end

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
